spi_bridge: RTL

//  SPI mode-0 target that turns serial frames into the single-cycle read/write/addr/data_write

---
 rtl/spi_bridge_pkg.sv | 18 +
 rtl/spi_bridge_if.sv | 26 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_bridge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-file bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        RD   = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int BYTE_BITS  = 8;
    localparam int CNT_W      = $clog2(BYTE_BITS);

endpackage

// File: rtl/spi_bridge_if.sv
// SPI pins plus register-file strobe bus; the bridge connects through the slave modport.
interface spi_bridge_if;
    import spi_bridge_pkg::*;

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic              frame_err;

    modport slave (
        input  sclk, cs_n, mosi, data_read,
        output miso, read, write, addr, data_write, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, data_read,
        input  miso, read, write, addr, data_write, frame_err
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses of the synced level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Chain and edge history reset low so a cs_n held low through reset yields no fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 target producing read/write strobes for the PWM register file.
// Optional address auto-increment bursts: define SPI_BRIDGE_AUTO_INC_EN.
module spi_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int READ_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    spi_bridge_if.slave spi_if
);

    localparam int RD_CNT_W = $clog2(READ_CYCLES);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(spi_if.sclk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_if.cs_n),
        .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_if.mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-2:0]   tx_q, tx_d;
    logic                is_wr_q, is_wr_d;
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_write_q, data_write_d;
    logic                miso_q, miso_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                frame_err_q, frame_err_d;
    logic [DATA_W-1:0]   rx_byte;
    logic                last_bit;
`ifdef SPI_BRIDGE_AUTO_INC_EN
    logic                burst_q, burst_d;
`endif

    assign rx_byte  = {shift_q, mosi_s};
    assign last_bit = (bit_cnt_q == CNT_W'(BYTE_BITS - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        is_wr_d      = is_wr_q;
        rd_cnt_d     = rd_cnt_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        miso_d       = miso_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        frame_err_d  = 1'b0;
`ifdef SPI_BRIDGE_AUTO_INC_EN
        burst_d      = burst_q;
`endif
        if (cs_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            miso_d      = 1'b0;
            frame_err_d = (bit_cnt_q != '0);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
`ifdef SPI_BRIDGE_AUTO_INC_EN
                        burst_d   = 1'b0;
`endif
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d   = rx_byte[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            addr_d  = rx_byte[ADDR_W-1:0];
                            is_wr_d = rx_byte[CMD_WR_BIT];
                            if (rx_byte[CMD_WR_BIT]) begin
                                state_d = DATA;
                            end else begin
                                state_d  = RD;
                                read_d   = 1'b1;
                                rd_cnt_d = '0;
                            end
                        end
                    end
                end
                RD: begin
                    if (rd_cnt_q == RD_CNT_W'(READ_CYCLES - 1)) begin
                        tx_d    = spi_if.data_read[DATA_W-2:0];
                        miso_d  = spi_if.data_read[DATA_W-1];
                        state_d = DATA;
                    end else begin
                        read_d   = 1'b1;
                        rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                    end
                end
                DATA: begin
                    // The fall trailing a byte's last rise must not consume the freshly loaded bit7.
                    if (sclk_fall && !is_wr_q && bit_cnt_q != '0) begin
                        miso_d = tx_q[DATA_W-2];
                        tx_d   = {tx_q[DATA_W-3:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d   = rx_byte[DATA_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
`ifdef SPI_BRIDGE_AUTO_INC_EN
                            if (is_wr_q) begin
                                data_write_d = rx_byte;
                                write_d      = 1'b1;
                                burst_d      = 1'b1;
                                if (burst_q) addr_d = addr_q + ADDR_W'(1);
                            end else begin
                                addr_d   = addr_q + ADDR_W'(1);
                                state_d  = RD;
                                read_d   = 1'b1;
                                rd_cnt_d = '0;
                            end
`else
                            if (is_wr_q) begin
                                data_write_d = rx_byte;
                                write_d      = 1'b1;
                            end
                            miso_d  = 1'b0;
                            state_d = DONE;
`endif
                        end
                    end
                end
                DONE: miso_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            is_wr_q      <= 1'b0;
            rd_cnt_q     <= '0;
            addr_q       <= '0;
            data_write_q <= '0;
            miso_q       <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef SPI_BRIDGE_AUTO_INC_EN
            burst_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            is_wr_q      <= is_wr_d;
            rd_cnt_q     <= rd_cnt_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            miso_q       <= miso_d;
            read_q       <= read_d;
            write_q      <= write_d;
            frame_err_q  <= frame_err_d;
`ifdef SPI_BRIDGE_AUTO_INC_EN
            burst_q      <= burst_d;
`endif
        end
    end

    assign spi_if.miso       = miso_q;
    assign spi_if.read       = read_q;
    assign spi_if.write      = write_q;
    assign spi_if.addr       = addr_q;
    assign spi_if.data_write = data_write_q;
    assign spi_if.frame_err  = frame_err_q;

endmodule
